// File: rtl/pwm_pkg.sv
// pwm_pkg: shared channel-state type and default sizes for the pwm_bank block.
// The dead-time feature is selected with the PWM_BANK_DEADTIME_EN macro.
package pwm_pkg;

    // Default sizes: 8-bit period counter, three output pairs, 6-bit dead time.
    localparam int PWM_N_DEFAULT        = 8;
    localparam int PWM_CHANNELS_DEFAULT = 3;
    localparam int PWM_DEAD_W_DEFAULT   = 6;

    // Per-channel output state. DEAD keeps both switches open while the
    // opposite side is allowed to turn off.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DEAD = 2'd3
    } chan_state_t;

endpackage

// File: rtl/pwm_bank_if.sv
// pwm_bank_if: control and output bundle of the pwm_bank block.
// master drives the run/step/duty controls, slave is the PWM bank itself.
interface pwm_bank_if
    import pwm_pkg::*;
#(
    parameter int N        = PWM_N_DEFAULT,
    parameter int CHANNELS = PWM_CHANNELS_DEFAULT,
    parameter int DEAD_W   = PWM_DEAD_W_DEFAULT
);

    logic                ena;
    logic                step;
    logic [N-1:0]        duty [CHANNELS];
    logic                load;
    logic [DEAD_W-1:0]   dead_time;
    logic [CHANNELS-1:0] pwm_out;
    logic [CHANNELS-1:0] pwm_not_out;
    logic                period_start;

    modport master (
        output ena, step, duty, load, dead_time,
        input  pwm_out, pwm_not_out, period_start
    );

    modport slave (
        input  ena, step, duty, load, dead_time,
        output pwm_out, pwm_not_out, period_start
    );

endinterface

// File: rtl/pwm_deadtime_channel.sv
// pwm_deadtime_channel: one complementary output pair driven from the raw
// compare bit. With PWM_BANK_DEADTIME_EN defined it runs the OFF/HI/LO/DEAD
// state machine with a reloadable dead counter; otherwise it is a plain
// registered complementary output and dead_time_i is not used.
module pwm_deadtime_channel
    import pwm_pkg::*;
#(
    parameter int DEAD_W = PWM_DEAD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_i,
    input  logic              raw_i,
    input  logic [DEAD_W-1:0] dead_time_i,
    output logic              hi_o,
    output logic              lo_o
);

`ifdef PWM_BANK_DEADTIME_EN

    chan_state_t       state_q;
    logic              target_q;
    logic [DEAD_W-1:0] dcnt_q;
    logic              hi_q;
    logic              lo_q;
    logic              deadZero;

    assign deadZero = (dead_time_i == '0);

    // Channel FSM: every move between sides passes through DEAD for
    // dead_time cycles, re-measured whenever the requested side flips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OFF;
            target_q <= 1'b0;
            dcnt_q   <= '0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
        end else if (!ena_i) begin
            state_q  <= OFF;
            dcnt_q   <= '0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (deadZero) begin
                        state_q <= raw_i ? HI : LO;
                        hi_q    <= raw_i;
                        lo_q    <= ~raw_i;
                    end else begin
                        state_q  <= DEAD;
                        target_q <= raw_i;
                        dcnt_q   <= dead_time_i;
                        hi_q     <= 1'b0;
                        lo_q     <= 1'b0;
                    end
                end
                HI: begin
                    if (!raw_i) begin
                        if (deadZero) begin
                            state_q <= LO;
                            hi_q    <= 1'b0;
                            lo_q    <= 1'b1;
                        end else begin
                            state_q  <= DEAD;
                            target_q <= 1'b0;
                            dcnt_q   <= dead_time_i;
                            hi_q     <= 1'b0;
                            lo_q     <= 1'b0;
                        end
                    end
                end
                LO: begin
                    if (raw_i) begin
                        if (deadZero) begin
                            state_q <= HI;
                            hi_q    <= 1'b1;
                            lo_q    <= 1'b0;
                        end else begin
                            state_q  <= DEAD;
                            target_q <= 1'b1;
                            dcnt_q   <= dead_time_i;
                            hi_q     <= 1'b0;
                            lo_q     <= 1'b0;
                        end
                    end
                end
                DEAD: begin
                    if (raw_i != target_q) begin
                        if (deadZero) begin
                            state_q <= raw_i ? HI : LO;
                            hi_q    <= raw_i;
                            lo_q    <= ~raw_i;
                        end else begin
                            target_q <= raw_i;
                            dcnt_q   <= dead_time_i;
                        end
                    end else if (dcnt_q <= DEAD_W'(1)) begin
                        state_q <= target_q ? HI : LO;
                        hi_q    <= target_q;
                        lo_q    <= ~target_q;
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= OFF;
                    hi_q    <= 1'b0;
                    lo_q    <= 1'b0;
                end
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

`else

    logic hi_q;
    logic lo_q;
    logic dead_time_unused;

    assign dead_time_unused = ^dead_time_i;

    // Without dead time the pair simply follows the compare, one cycle late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 1'b0;
            lo_q <= 1'b0;
        end else begin
            hi_q <= ena_i & raw_i;
            lo_q <= ena_i & ~raw_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

`endif

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: shared period counter, double-buffered duty registers and one
// complementary output pair per channel. Define PWM_BANK_DEADTIME_EN to
// insert dead time between the high-side and low-side outputs.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int N        = PWM_N_DEFAULT,
    parameter int CHANNELS = PWM_CHANNELS_DEFAULT,
    parameter int DEAD_W   = PWM_DEAD_W_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    pwm_bank_if.slave bus
);

    logic [N-1:0]        cnt_q;
    logic [N-1:0]        cnt_d;
    logic [N-1:0]        shadow_q [CHANNELS];
    logic [N-1:0]        active_q [CHANNELS];
    logic                wrap;
    logic                period_start_q;
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] hi;
    logic [CHANNELS-1:0] lo;

    assign wrap = bus.ena & bus.step & (cnt_q == '1);

    // Next counter value: cleared while disabled, advanced on each step.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.ena) begin
            cnt_d = '0;
        end else if (bus.step) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Period counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Shadow duty captures the requested duty whenever load is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (bus.load) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= bus.duty[i];
            end
        end
    end

    // Active duty follows the shadow freely while stopped, else only at wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_q[i] <= '0;
            end
        end else if (!bus.ena || wrap) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // One-cycle marker following each counter wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= wrap;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : gChan
        assign raw[g] = (cnt_q < active_q[g]);

        pwm_deadtime_channel #(
            .DEAD_W (DEAD_W)
        ) uChan (
            .clk         (clk),
            .rst         (rst),
            .ena_i       (bus.ena),
            .raw_i       (raw[g]),
            .dead_time_i (bus.dead_time),
            .hi_o        (hi[g]),
            .lo_o        (lo[g])
        );
    end

    assign bus.pwm_out      = hi;
    assign bus.pwm_not_out  = lo;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: randomized scoreboard bench for pwm_bank. A reference model
// predicts each cycle's outputs from the duty/counter rules and a
// "side held long enough" view of dead time; a monitor compares them.
module tb_pwm_bank;
    import pwm_pkg::*;

    localparam int N      = 8;
    localparam int CH     = 3;
    localparam int DW     = 6;
    localparam int PERIOD = 1 << N;
`ifdef PWM_BANK_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CH-1:0] hi;
        logic [CH-1:0] lo;
        logic          ps;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    expect_t expQ[$];
    int      checks = 0;
    int      errors = 0;

    // Reference model state: counter, duty buffers and the current run of
    // identical compare results seen by each channel while enabled.
    int mCnt = 0;
    int mShadow [CH];
    int mActive [CH];
    int runVal  [CH];
    int runLen  [CH];
    int runDead [CH];

    pwm_bank_if #(.N(N), .CHANNELS(CH), .DEAD_W(DW)) bus ();

    pwm_bank #(.N(N), .CHANNELS(CH), .DEAD_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its prediction and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Effective dead time seen by the model for the current build.
    function automatic int effDead(input int d);
        return DT_EN ? d : 0;
    endfunction

    // Occasionally pick the extreme duties so the edge cases recur.
    function automatic logic [N-1:0] pickDuty();
        int r;
        r = int'($urandom_range(9));
        if (r == 0) return '0;
        if (r == 1) return '1;
        return N'($urandom);
    endfunction

    // Model: at every edge predict what the outputs show after that edge.
    // A side drives only once the compare has held the same value for
    // dead_time+1 consecutive enabled edges (dead_time fixed when the run began).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mCnt = 0;
            for (int i = 0; i < CH; i++) begin
                mShadow[i] = 0;
                mActive[i] = 0;
                runLen[i]  = 0;
                runVal[i]  = 0;
                runDead[i] = 0;
            end
            expQ.delete();
        end else begin
            expect_t e;
            int      rawV;
            e = '0;
            for (int i = 0; i < CH; i++) begin
                rawV = (mCnt < mActive[i]) ? 1 : 0;
                if (!bus.ena) begin
                    runLen[i] = 0;
                end else begin
                    if (runLen[i] == 0 || runVal[i] != rawV) begin
                        runVal[i]  = rawV;
                        runLen[i]  = 1;
                        runDead[i] = effDead(int'(bus.dead_time));
                    end else if (runLen[i] < 1000) begin
                        runLen[i]++;
                    end
                    if (runLen[i] >= runDead[i] + 1) begin
                        e.hi[i] = (runVal[i] == 1);
                        e.lo[i] = (runVal[i] == 0);
                    end
                end
            end
            e.ps = bus.ena && bus.step && (mCnt == PERIOD - 1);
            if (!bus.ena || e.ps) begin
                for (int i = 0; i < CH; i++) mActive[i] = mShadow[i];
            end
            if (bus.load) begin
                for (int i = 0; i < CH; i++) mShadow[i] = int'(bus.duty[i]);
            end
            if (!bus.ena) mCnt = 0;
            else if (bus.step) mCnt = (mCnt + 1) % PERIOD;
            expQ.push_back(e);
        end
    end

    // Monitor: every cycle the DUT presents outputs; pop and compare.
    always @(negedge clk) begin
        if (!rst && expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            checkOutput("pwm_out", 32'(bus.pwm_out), 32'(e.hi));
            checkOutput("pwm_not_out", 32'(bus.pwm_not_out), 32'(e.lo));
            checkOutput("period_start", 32'(bus.period_start), 32'(e.ps));
            checkOutput("overlap", 32'(bus.pwm_out & bus.pwm_not_out), 32'd0);
        end
    end

    // Drive controls for a number of cycles with optional random loads,
    // ena toggles (per mille) and dead_time changes.
    task automatic applyStimulus(input int cycles, input int stepEvery, input int loadPct,
                                 input int enaTogglePm, input bit randDead);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            bus.step = ((c % stepEvery) == 0);
            bus.load = 1'b0;
            if (int'($urandom_range(99)) < loadPct) begin
                bus.load = 1'b1;
                for (int i = 0; i < CH; i++) bus.duty[i] = pickDuty();
            end
            if (int'($urandom_range(999)) < enaTogglePm) bus.ena = ~bus.ena;
            if (randDead && $urandom_range(99) < 3) bus.dead_time = DW'($urandom_range(8));
        end
    endtask

    // Load one set of duties with a single-cycle load pulse.
    task automatic loadDuty(input int d0, input int d1, input int d2);
        @(posedge clk);
        #1;
        bus.duty[0] = N'(d0);
        bus.duty[1] = N'(d1);
        bus.duty[2] = N'(d2);
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    // Wait (bounded) for period_start, then count one full period of a channel.
    task automatic measurePeriod(input int ch, input int expHi, input int expLo);
        int waited = 0;
        int hiCnt  = 0;
        int loCnt  = 0;
        int psCnt  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.period_start && waited < 4 * PERIOD);
        if (!bus.period_start) begin
            checks++;
            errors++;
            $display("[TB] FAIL period_start_wait: got no pulse in %0d cycles, expected one", waited);
            return;
        end
        for (int c = 0; c < PERIOD; c++) begin
            if (c > 0) @(negedge clk);
            hiCnt += int'(bus.pwm_out[ch]);
            loCnt += int'(bus.pwm_not_out[ch]);
            psCnt += int'(bus.period_start);
        end
        checkOutput("high_count", 32'(hiCnt), 32'(expHi));
        checkOutput("low_count", 32'(loCnt), 32'(expLo));
        checkOutput("period_start_count", 32'(psCnt), 32'd1);
    endtask

    initial begin
        int d;
        bus.ena       = 1'b0;
        bus.step      = 1'b0;
        bus.load      = 1'b0;
        bus.dead_time = '0;
        for (int i = 0; i < CH; i++) bus.duty[i] = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_pwm_out", 32'(bus.pwm_out), 32'd0);
        checkOutput("reset_pwm_not_out", 32'(bus.pwm_not_out), 32'd0);
        checkOutput("reset_period_start", 32'(bus.period_start), 32'd0);
        rst = 1'b0;

        // 64/256 duty with no dead time.
        $display("[TB] duty 64, dead_time 0");
        loadDuty(64, int'(pickDuty()), int'(pickDuty()));
        @(posedge clk);
        #1;
        bus.ena  = 1'b1;
        bus.step = 1'b1;
        measurePeriod(0, 64, 192);

        // Dead time 4 at 50% duty on every channel.
        $display("[TB] duty 128, dead_time 4");
        bus.dead_time = DW'(4);
        loadDuty(128, 128, 128);
        d = effDead(4);
        measurePeriod(1, 128 - d, 128 - d);

        // Mid-period load of 200: takes effect from the next wrap.
        $display("[TB] mid-period load of 200");
        applyStimulus(100, 1, 0, 0, 1'b0);
        loadDuty(200, 128, 128);
        measurePeriod(0, 200 - d, 56 - d);

        // Extreme duties, slow stepping, long dead time swallows short pulses.
        $display("[TB] duty 0 / 255, step every 3, dead_time 5");
        bus.dead_time = DW'(5);
        loadDuty(0, 255, int'(pickDuty()));
        applyStimulus(3 * PERIOD * 2 + 20, 3, 0, 0, 1'b0);

        // Random operation.
        $display("[TB] random stimulus");
        applyStimulus(3000, 1, 2, 3, 1'b1);
        bus.ena = 1'b1;
        applyStimulus(1500, 2, 2, 0, 1'b1);

        // Drop ena mid-period, restart, then reset during the dead window.
        $display("[TB] ena drop and reset mid dead time");
        bus.dead_time = DW'(6);
        bus.step      = 1'b1;
        applyStimulus(90, 1, 0, 0, 1'b0);
        bus.ena = 1'b0;
        applyStimulus(6, 1, 0, 0, 1'b0);
        bus.ena = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_pwm_out", 32'(bus.pwm_out), 32'd0);
        checkOutput("async_reset_pwm_not_out", 32'(bus.pwm_not_out), 32'd0);
        checkOutput("async_reset_period_start", 32'(bus.period_start), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(2 * PERIOD + 40, 1, 1, 0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
